// File: rtl/frame_rcv_chk_if.sv
// Word stream from the frame sequencer plus the checker's forwarded data and status.
// Ports: valid/seq/last_wrd/din/samp_max/err_clr flow toward the checker; dout/dv/samp_idx/
//        wrd_idx/frm_done/evt_done/seq_err/chk_err/cnt_err/err_cnt/rcv_state flow back out.
interface frame_rcv_chk_if #(
   parameter int DW  = 16,
   parameter int ECW = 8
);
   logic           valid;
   logic [6:0]     seq;
   logic           last_wrd;
   logic [DW-1:0]  din;
   logic [6:0]     samp_max;
   logic           err_clr;
   logic [DW-1:0]  dout;
   logic           dv;
   logic [6:0]     samp_idx;
   logic [6:0]     wrd_idx;
   logic           frm_done;
   logic           evt_done;
   logic           seq_err;
   logic           chk_err;
   logic           cnt_err;
   logic [ECW-1:0] err_cnt;
   logic [1:0]     rcv_state;

   // Sequencer / slow-control side.
   modport master (
      output valid, seq, last_wrd, din, samp_max, err_clr,
      input  dout, dv, samp_idx, wrd_idx, frm_done, evt_done,
             seq_err, chk_err, cnt_err, err_cnt, rcv_state
   );

   // Checker side.
   modport slave (
      input  valid, seq, last_wrd, din, samp_max, err_clr,
      output dout, dv, samp_idx, wrd_idx, frm_done, evt_done,
             seq_err, chk_err, cnt_err, err_cnt, rcv_state
   );
endinterface

// File: rtl/frame_rcv_chk.sv
// Receive checker for sample frames: forwards 96 data words per frame, checks sequence/checksum/sample count.
// Latency: 1 cycle from accepted word to every registered output.
// Backpressure: none; every VALID/LAST_WRD cycle is consumed, idle cycles hold state.
// Ports: clk, rst_n (async active-low) plain; all stream/status signals through bus (slave modport).
module frame_rcv_chk #(
   parameter int DW  = 16,
   parameter int ECW = 8
) (
   input logic            clk,
   input logic            rst_n,
   frame_rcv_chk_if.slave bus
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_DATA = 2'd1;
   localparam logic [1:0] S_TAIL = 2'd2;
   localparam logic [1:0] S_BTWN = 2'd3;

   localparam logic [6:0]     SEQ_LAST_DATA = 7'd95;
   localparam logic [6:0]     SEQ_CSUM      = 7'd99;
   localparam logic [6:0]     SAMP_LIM      = 7'd127;
   localparam logic [ECW-1:0] CNT_SAT       = '1;

   logic [1:0]     st_q, st_d;
   logic [6:0]     samp_q, samp_d;
   logic [6:0]     exp_q, exp_d;
   logic [DW-1:0]  sum_q, sum_d;

   logic [DW-1:0]  dout_q, dout_d;
   logic           dv_q, dv_d;
   logic [6:0]     samp_idx_q, samp_idx_d;
   logic [6:0]     wrd_idx_q, wrd_idx_d;
   logic           frm_done_q, frm_done_d;
   logic           evt_done_q, evt_done_d;
   logic           seq_err_q, seq_err_d;
   logic           chk_err_q, chk_err_d;
   logic           cnt_err_q, cnt_err_d;
   logic [ECW-1:0] err_cnt_q, err_cnt_d;

   logic           seq_ev, chk_ev, cnt_ev;
   logic           fwd;

   always_comb begin
      st_d       = st_q;
      samp_d     = samp_q;
      exp_d      = exp_q;
      sum_d      = sum_q;
      fwd        = 1'b0;
      frm_done_d = 1'b0;
      evt_done_d = 1'b0;
      seq_ev     = 1'b0;
      chk_ev     = 1'b0;
      cnt_ev     = 1'b0;

      case (st_q)
         S_IDLE: begin
            // LAST_WRD takes priority over a coincident VALID.
            if (bus.last_wrd) begin
               seq_ev = 1'b1;
            end else if (bus.valid) begin
               if (bus.seq == 7'd0) begin
                  st_d   = S_DATA;
                  samp_d = 7'd0;
                  exp_d  = 7'd1;
                  sum_d  = bus.din;
                  fwd    = 1'b1;
               end else begin
                  seq_ev = 1'b1;
               end
            end
         end

         S_DATA, S_TAIL: begin
            if (bus.last_wrd || (bus.valid && (bus.seq != exp_q))) begin
               // Abort the event; the offending word is dropped.
               seq_ev     = 1'b1;
               evt_done_d = 1'b1;
               st_d       = S_IDLE;
            end else if (bus.valid) begin
               if (st_q == S_DATA) begin
                  fwd   = 1'b1;
                  sum_d = sum_q + bus.din;
                  exp_d = exp_q + 7'd1;
                  if (bus.seq == SEQ_LAST_DATA) begin
                     st_d = S_TAIL;
                  end
               end else if (bus.seq == SEQ_CSUM) begin
                  chk_ev     = (bus.din != sum_q);
                  frm_done_d = 1'b1;
                  st_d       = S_BTWN;
               end else begin
                  // Tail words ahead of the checksum are only sequence-checked.
                  exp_d = exp_q + 7'd1;
               end
            end
         end

         S_BTWN: begin
            if (bus.last_wrd) begin
               // End of event is honoured even with a coincident VALID, which is still an error.
               cnt_ev     = (samp_q != bus.samp_max);
               seq_ev     = bus.valid;
               evt_done_d = 1'b1;
               st_d       = S_IDLE;
            end else if (bus.valid) begin
               if ((bus.seq != 7'd0) || (samp_q == SAMP_LIM)) begin
                  seq_ev     = 1'b1;
                  evt_done_d = 1'b1;
                  st_d       = S_IDLE;
               end else begin
                  st_d   = S_DATA;
                  samp_d = samp_q + 7'd1;
                  exp_d  = 7'd1;
                  sum_d  = bus.din;
                  fwd    = 1'b1;
               end
            end
         end

         default: begin
            st_d = S_IDLE;
         end
      endcase
   end

   // Forwarded word carries the sample index of the frame it belongs to.
   always_comb begin
      dv_d       = fwd;
      dout_d     = fwd ? bus.din : dout_q;
      samp_idx_d = fwd ? samp_d  : samp_idx_q;
      wrd_idx_d  = fwd ? bus.seq : wrd_idx_q;
   end

   // Sticky flags and counter: a new error beats a same-cycle clear, and any number
   // of simultaneous errors counts as one event.
   always_comb begin
      seq_err_d = (seq_err_q & ~bus.err_clr) | seq_ev;
      chk_err_d = (chk_err_q & ~bus.err_clr) | chk_ev;
      cnt_err_d = (cnt_err_q & ~bus.err_clr) | cnt_ev;
      err_cnt_d = bus.err_clr ? '0 : err_cnt_q;
      if ((seq_ev || chk_ev || cnt_ev) && (err_cnt_d != CNT_SAT)) begin
         err_cnt_d = err_cnt_d + ECW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q       <= S_IDLE;
         samp_q     <= '0;
         exp_q      <= '0;
         sum_q      <= '0;
         dout_q     <= '0;
         dv_q       <= 1'b0;
         samp_idx_q <= '0;
         wrd_idx_q  <= '0;
         frm_done_q <= 1'b0;
         evt_done_q <= 1'b0;
         seq_err_q  <= 1'b0;
         chk_err_q  <= 1'b0;
         cnt_err_q  <= 1'b0;
         err_cnt_q  <= '0;
      end else begin
         st_q       <= st_d;
         samp_q     <= samp_d;
         exp_q      <= exp_d;
         sum_q      <= sum_d;
         dout_q     <= dout_d;
         dv_q       <= dv_d;
         samp_idx_q <= samp_idx_d;
         wrd_idx_q  <= wrd_idx_d;
         frm_done_q <= frm_done_d;
         evt_done_q <= evt_done_d;
         seq_err_q  <= seq_err_d;
         chk_err_q  <= chk_err_d;
         cnt_err_q  <= cnt_err_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign bus.dout      = dout_q;
   assign bus.dv        = dv_q;
   assign bus.samp_idx  = samp_idx_q;
   assign bus.wrd_idx   = wrd_idx_q;
   assign bus.frm_done  = frm_done_q;
   assign bus.evt_done  = evt_done_q;
   assign bus.seq_err   = seq_err_q;
   assign bus.chk_err   = chk_err_q;
   assign bus.cnt_err   = cnt_err_q;
   assign bus.err_cnt   = err_cnt_q;
   assign bus.rcv_state = st_q;

endmodule
